alu_rr_arbiter: RTL and testbench
=================================

ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; fixed at 4 for this revision.
REQ-002 Parameter DW, default 4, operand/result width; fixed at 4 for this revision.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  4  per-requester request valid.
REQ-006 req_a  input  16  operand A, 4 bits per requester, requester i at [4i+3:4i].
REQ-007 req_b  input  16  operand B, same packing as req_a.
REQ-008 req_fncode  input  32  one-hot function code, 8 bits per requester, requester i at [8i+7:8i].
REQ-009 hold  input  1  when 1, no new grants are made; the pipeline still drains.
REQ-010 req_ready  output  4  per-requester grant, combinational, at most one bit set.
REQ-011 rsp_valid  output  1  one-cycle response pulse.
REQ-012 rsp_id  output  2  requester index of the response.
REQ-013 rsp_result  output  4  ALU result.
REQ-014 rsp_parity  output  1  XOR of the four rsp_result bits.
REQ-015 rsp_err  output  1  fncode was not one-hot.

Function
REQ-016 Transfer: a request is accepted on a posedge where req_valid[i] and req_ready[i] are both 1; the requester holds its operands and fncode stable while valid and not ready.
REQ-017 Grant: req_ready[i] = 1 only when hold = 0, rst_n = 1, req_valid[i] = 1, and i is the first valid index searching ptr, ptr+1, ... modulo 4.
REQ-018 Pointer: on an accept from requester i, ptr becomes (i+1) mod 4; otherwise ptr holds; wrap 3 -> 0.
REQ-019 Stage 1, at the accept edge: capture A, B, the requester id, the encoded 3-bit opcode and the error flag; set s1_valid.
REQ-020 Encoding: fncode bit k set, all other bits clear -> opcode k; zero or more than one bit set -> err = 1, opcode don't-care.
REQ-021 Opcode map: 0 A+B, 1 A-B, 2 A^B, 3 A|B, 4 A&B, 5 ~(A|B), 6 ~(A&B), 7 ~(A^B); all results modulo 16, carry and borrow discarded.
REQ-022 Stage 2, on the next edge: register the result, parity, id and err from stage 1; rsp_valid = the previous s1_valid.
REQ-023 Latency: an accept at edge N gives rsp_valid high for the single cycle following edge N+1; there is no response backpressure.
REQ-024 Throughput: one accept per cycle; responses return in accept order.
REQ-025 Error response: when err = 1, rsp_result = 0 and rsp_parity = 0.
REQ-026 When rsp_valid = 0, rsp_id, rsp_result, rsp_parity and rsp_err are 0.
REQ-027 Hold raised with requests in flight: no new accepts; in-flight responses still emerge on schedule.

Reset
REQ-028 On rst_n = 0, immediately and without waiting for a clock: ptr = 0, s1_valid = 0, rsp_valid = 0, and all rsp_* outputs = 0.
REQ-029 Reset asserted mid-operation drops in-flight requests with no response; req_ready is 0 throughout reset.
REQ-030 After rst_n deasserts, the first grant search starts at index 0.

Structure
REQ-031 A shared package holds the opcode constants (OP_ADD .. OP_XNOR), NREQ, DW and the one-hot-to-opcode encode function.
REQ-032 A sub-module alu_rr_grant implements the combinational round-robin grant from req_valid, ptr and hold; pointer and pipeline registers stay in the top module.

Verification
REQ-033 Requester 0 only, A=5, B=6, fncode=8'h01, accepted at edge N -> after edge N+1: rsp_valid=1, id=0, result=4'b1011, parity=1, err=0.
REQ-034 Requester 2, A=2, B=3, fncode=8'h02 -> result=4'b1111, parity=0; then A=12, B=5, fncode=8'h80 -> result=4'b0110, parity=0.
REQ-035 All four requesters valid and held from reset -> grants 0, 1, 2, 3 on consecutive edges, then 0 again; responses in the same order, with no bubbles.
REQ-036 Requester 1, fncode=8'h03, then a second request with fncode=8'h00 -> both responses have err=1, result=0, parity=0; ptr still advances.
REQ-037 Two accepts in flight, rst_n pulsed low between edges -> outputs go to 0 immediately, no response ever emerges, and the next grant goes to the lowest valid index.
REQ-038 Continuous requests from 1 and 3 with hold=1 for 3 cycles -> req_ready=0 during hold; the in-flight response still appears; after release, grants resume from the stored ptr.

Source files
------------

// File: rtl/alu_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_arbiter_pkg
// Description : Shared definitions for the round-robin ALU arbiter.
//               - Sizing constants: requester count, data width and the
//                 widths derived from them.
//               - Opcode enumeration, OP_ADD through OP_XNOR.
//               - One-hot function-code encoder.
//               - ALU evaluation helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_rr_arbiter_pkg;

    localparam int NREQ = 4;   // number of requesters
    localparam int DW   = 4;   // operand / result width
    localparam int IDW  = 2;   // requester index width, log2(NREQ)
    localparam int FCW  = 8;   // one-hot function code width per requester
    localparam int OPW  = 3;   // encoded opcode width

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_OR   = 3'd3,
        OP_AND  = 3'd4,
        OP_NOR  = 3'd5,
        OP_NAND = 3'd6,
        OP_XNOR = 3'd7
    } opcode_t;

    typedef struct packed {
        logic    err;   // function code was not exactly one-hot
        opcode_t op;    // meaningful only when err is clear
    } enc_t;

    // One-hot to binary. An all-zero code, or one with more than one bit
    // set, is flagged as an error. In that case the opcode is whatever the
    // priority scan leaves behind, and downstream logic ignores it.
    function automatic enc_t fncode_encode(input logic [FCW-1:0] fn);
        enc_t r;
        r.op  = OP_ADD;
        // x & (x-1) clears the lowest set bit. The result is non-zero
        // only when at least two bits are set.
        r.err = (fn == '0) || ((fn & (fn - FCW'(1))) != '0);
        for (int k = 0; k < FCW; k++) begin
            if (fn[k]) begin
                r.op = opcode_t'(k[OPW-1:0]);
            end
        end
        return r;
    endfunction

    // All arithmetic is modulo 2**DW. Carry and borrow are dropped.
    function automatic logic [DW-1:0] alu_eval(input opcode_t         op,
                                               input logic [DW-1:0]   a,
                                               input logic [DW-1:0]   b);
        logic [DW-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_NOR:  r = ~(a | b);
            OP_NAND: r = ~(a & b);
            OP_XNOR: r = ~(a ^ b);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage : alu_rr_arbiter_pkg
`default_nettype wire

// File: rtl/alu_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_arbiter_if
// Description : Request/response bundle for the round-robin ALU arbiter.
//               Request side, driven by the requesters:
//                 req_valid, req_a, req_b, req_fncode, hold
//               Grant and response side, driven by the arbiter:
//                 req_ready, rsp_valid, rsp_id, rsp_result, rsp_parity,
//                 rsp_err
//               Modports:
//                 master - requester / environment side
//                 slave  - arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_rr_arbiter_if
    import alu_rr_arbiter_pkg::*;
();

    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_a;
    logic [NREQ*DW-1:0]  req_b;
    logic [NREQ*FCW-1:0] req_fncode;
    logic                hold;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_result;
    logic                rsp_parity;
    logic                rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_fncode, hold,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_parity, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_fncode, hold,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_parity, rsp_err
    );

endinterface : alu_rr_arbiter_if
`default_nettype wire

// File: rtl/alu_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_grant
// Description : Combinational round-robin grant. Searches the requesters
//               starting at ptr, wrapping modulo NREQ, and grants the first
//               valid one. No grant is made while hold is high.
// Ports       : req_valid [NREQ] in  - per-requester valid
//               ptr       [IDW]  in  - first index to search
//               hold             in  - suppress all grants
//               grant     [NREQ] out - one-hot (or zero) grant vector
//               grant_id  [IDW]  out - index of the granted requester
//               grant_any        out - a grant is being made
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_grant
    import alu_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            hold,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_any
);

    logic [IDW-1:0] w_idx;

    // The index is carried in IDW bits, so ptr + k wraps naturally. This
    // depends on NREQ being a power of two, which holds for this revision.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        w_idx     = '0;
        if (!hold) begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = ptr + IDW'(k);
                if (!grant_any && req_valid[w_idx]) begin
                    grant[w_idx] = 1'b1;
                    grant_id     = w_idx;
                    grant_any    = 1'b1;
                end
            end
        end
    end

endmodule : alu_rr_grant
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_arbiter
// Description : Round-robin arbiter in front of a two-stage ALU pipeline.
//               Each cycle one requester is granted. At the accept edge its
//               operands and encoded opcode are captured into stage 1. One
//               edge later the result leaves stage 2 as a single-cycle
//               response pulse. There is no response backpressure.
// Ports       : clk    in - clock, rising edge active
//               rst_n  in - asynchronous active-low reset
//               bus       - alu_rr_arbiter_if.slave
//                           requests: req_valid, req_a, req_b, req_fncode, hold
//                           grant:    req_ready
//                           response: rsp_valid, rsp_id, rsp_result,
//                                     rsp_parity, rsp_err
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    alu_rr_arbiter_if.slave bus
);

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    logic [IDW-1:0]  r_ptr;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_id;
    logic            w_grant_any;
    logic            w_accept;

    alu_rr_grant u_grant (
        .req_valid (bus.req_valid),
        .ptr       (r_ptr),
        .hold      (bus.hold),
        .grant     (w_grant),
        .grant_id  (w_grant_id),
        .grant_any (w_grant_any)
    );

    // req_ready must read 0 for the whole time reset is asserted, including
    // the part of a cycle before the next clock edge. The grant is therefore
    // gated directly with rst_n rather than relying on the registers alone.
    assign bus.req_ready = w_grant & {NREQ{rst_n}};
    assign w_accept      = w_grant_any & rst_n;

    // ------------------------------------------------------------------
    // Operand selection for the granted requester
    // ------------------------------------------------------------------
    logic [DW-1:0]  w_sel_a;
    logic [DW-1:0]  w_sel_b;
    logic [FCW-1:0] w_sel_fn;
    enc_t           w_enc;

    assign w_sel_a  = bus.req_a[int'(w_grant_id)*DW +: DW];
    assign w_sel_b  = bus.req_b[int'(w_grant_id)*DW +: DW];
    assign w_sel_fn = bus.req_fncode[int'(w_grant_id)*FCW +: FCW];
    assign w_enc    = fncode_encode(w_sel_fn);

    // ------------------------------------------------------------------
    // Round-robin pointer: the next search starts just past the last
    // winner, so a requester that was just served has lowest priority.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_grant_id + IDW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture at the accept edge
    // ------------------------------------------------------------------
    logic           r_s1_valid;
    logic [IDW-1:0] r_s1_id;
    logic [DW-1:0]  r_s1_a;
    logic [DW-1:0]  r_s1_b;
    opcode_t        r_s1_op;
    logic           r_s1_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OP_ADD;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            // Payload registers load only on an accept. Stage 2 ignores
            // them whenever r_s1_valid is low, so stale contents are harmless.
            if (w_accept) begin
                r_s1_id  <= w_grant_id;
                r_s1_a   <= w_sel_a;
                r_s1_b   <= w_sel_b;
                r_s1_op  <= w_enc.op;
                r_s1_err <= w_enc.err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: compute and register the response
    // ------------------------------------------------------------------
    logic [DW-1:0]  w_alu_result;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [DW-1:0]  r_rsp_result;
    logic           r_rsp_parity;
    logic           r_rsp_err;

    assign w_alu_result = alu_eval(r_s1_op, r_s1_a, r_s1_b);

    // Every response field is forced to zero when no response is present.
    // On an error, result and parity are also zero, because the opcode is
    // meaningless in that case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_parity <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rsp_id     <= r_s1_id;
                r_rsp_err    <= r_s1_err;
                r_rsp_result <= r_s1_err ? '0   : w_alu_result;
                r_rsp_parity <= r_s1_err ? 1'b0 : ^w_alu_result;
            end else begin
                r_rsp_id     <= '0;
                r_rsp_err    <= 1'b0;
                r_rsp_result <= '0;
                r_rsp_parity <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_parity = r_rsp_parity;
    assign bus.rsp_err    = r_rsp_err;

endmodule : alu_rr_arbiter
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rr_arbiter
// Description : Self-checking bench for alu_rr_arbiter.
//               - Directed scenarios, followed by a randomized phase.
//               - All checks are made against a reference model that holds
//                 a round-robin pointer and a queue of expected responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_arbiter;

    localparam int M_DIR  = 0;  // accepted requests are dropped
    localparam int M_KEEP = 1;  // accepted requesters immediately re-request
    localparam int M_RAND = 2;  // random arrivals and random hold

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    alu_rr_arbiter_if bus ();

    alu_rr_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int       due;
        int       id;
        logic [3:0] res;
        bit       par;
        bit       err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_ptr = 0;
    int   cyc   = 0;
    int   g_neg = -1;
    int   mode  = M_DIR;

    bit         sv[4];
    logic [3:0] sa[4];
    logic [3:0] sb[4];
    logic [7:0] sf[4];

    logic [3:0] last_res;
    bit         last_par;
    bit         last_err;
    int         last_id;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Behavioural ALU, computed directly from the function-code rules.
    function automatic void ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [7:0] fn,
                                    output logic [3:0] res, output bit par, output bit err);
        int r;
        int op;
        r   = 0;
        op  = -1;
        err = 1'b1;
        if ($countones(fn) == 1) begin
            err = 1'b0;
            for (int k = 0; k < 8; k++) if (fn[k]) op = k;
        end
        case (op)
            0: r = (int'(a) + int'(b)) % 16;
            1: r = (int'(a) - int'(b) + 16) % 16;
            2: r = int'(a ^ b);
            3: r = int'(a | b);
            4: r = int'(a & b);
            5: r = 15 - int'(a | b);
            6: r = 15 - int'(a & b);
            7: r = 15 - int'(a ^ b);
            default: r = 0;
        endcase
        res = 4'(r);
        par = ($countones(res) % 2) == 1;
    endfunction

    function automatic int ref_grant();
        if (rst_n !== 1'b1 || bus.hold) return -1;
        for (int off = 0; off < 4; off++) begin
            if (sv[(m_ptr + off) % 4]) return (m_ptr + off) % 4;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid[i]         = sv[i];
            bus.req_a[4*i +: 4]      = sa[i];
            bus.req_b[4*i +: 4]      = sb[i];
            bus.req_fncode[8*i +: 8] = sf[i];
        end
    endtask

    task automatic new_req(input int i);
        sa[i] = 4'($urandom);
        sb[i] = 4'($urandom);
        if ($urandom_range(0, 4) == 0) sf[i] = 8'($urandom);
        else                           sf[i] = 8'(1 << $urandom_range(0, 7));
        sv[i] = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [7:0] fn);
        sa[i] = a;
        sb[i] = b;
        sf[i] = fn;
        sv[i] = 1'b1;
        drive();
    endtask

    task automatic check_outputs();
        exp_t       e;
        logic [8:0] obs;
        logic [8:0] expv;
        int         g;
        g     = ref_grant();
        g_neg = g;
        check_val("ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        obs = {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_parity, bus.rsp_err};
        if (q.size() > 0 && q[0].due == cyc) begin
            e    = q.pop_front();
            expv = {1'b1, 2'(e.id), e.res, e.par, e.err};
        end else begin
            expv = '0;
        end
        check_val("rsp", 32'(obs), 32'(expv));
        if (bus.rsp_valid === 1'b1) begin
            last_res = bus.rsp_result;
            last_par = bus.rsp_parity;
            last_err = bus.rsp_err;
            last_id  = int'(bus.rsp_id);
        end
    endtask

    task automatic model_edge(output int g_edge);
        exp_t       e;
        logic [3:0] r;
        bit         p;
        bit         er;
        g_edge = -1;
        if (rst_n !== 1'b1) begin
            q.delete();
            m_ptr = 0;
        end else if (g_neg >= 0) begin
            g_edge = g_neg;
            ref_alu(sa[g_edge], sb[g_edge], sf[g_edge], r, p, er);
            e.due = cyc + 1;
            e.id  = g_edge;
            e.res = r;
            e.par = p;
            e.err = er;
            q.push_back(e);
            m_ptr = (g_edge + 1) % 4;
        end
    endtask

    task automatic update_stim(input int g_edge);
        if (g_edge >= 0) begin
            if (mode == M_KEEP)                                 new_req(g_edge);
            else if (mode == M_RAND && $urandom_range(0, 1) == 1) new_req(g_edge);
            else                                                sv[g_edge] = 1'b0;
        end
        if (mode == M_RAND) begin
            for (int i = 0; i < 4; i++) begin
                if (!sv[i] && $urandom_range(0, 2) == 0) new_req(i);
            end
            bus.hold = ($urandom_range(0, 5) == 0);
        end
        drive();
    endtask

    // One clock: check at the falling edge, update the model at the rising
    // edge, then drive new stimulus 1ns later.
    task automatic tick();
        int g_edge;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        cyc++;
        model_edge(g_edge);
        #1;
        update_stim(g_edge);
    endtask

    // Assert reset between edges, while responses are still in flight.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_ready", 32'(bus.req_ready), 32'd0);
        check_val("rst_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_parity, bus.rsp_err}), 32'd0);
        q.delete();
        m_ptr = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) sv[i] = 1'b0;
        drive();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            sv[i] = 1'b0; sa[i] = '0; sb[i] = '0; sf[i] = '0;
        end
        bus.hold = 1'b0;
        drive();
        last_res = '0; last_par = 1'b0; last_err = 1'b0; last_id = -1;

        // Power-on reset; outputs must clear without a clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        check_val("por_ready", 32'(bus.req_ready), 32'd0);
        check_val("por_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_parity, bus.rsp_err}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Requester 0: 5 + 6.
        mode = M_DIR;
        last_res = 4'h0; last_par = 1'b0; last_err = 1'b1;
        set_req(0, 4'd5, 4'd6, 8'h01);
        repeat (3) tick();
        check_val("add_res", 32'(last_res), 32'hB);
        check_val("add_par", 32'(last_par), 32'd1);
        check_val("add_err", 32'(last_err), 32'd0);
        check_val("add_id",  32'(last_id),  32'd0);

        // Requester 2: 2 - 3 wraps, then XNOR.
        set_req(2, 4'd2, 4'd3, 8'h02);
        tick();
        set_req(2, 4'd12, 4'd5, 8'h80);
        tick();
        tick();
        check_val("sub_res", 32'(last_res), 32'hF);
        check_val("sub_par", 32'(last_par), 32'd0);
        tick();
        check_val("xnor_res", 32'(last_res), 32'h6);
        check_val("xnor_par", 32'(last_par), 32'd0);
        check_val("xnor_id",  32'(last_id),  32'd2);

        // Requester 1: two malformed function codes.
        last_res = 4'hF; last_err = 1'b0;
        set_req(1, 4'd7, 4'd9, 8'h03);
        tick();
        set_req(1, 4'd3, 4'd4, 8'h00);
        tick();
        tick();
        check_val("err2_flag", 32'(last_err), 32'd1);
        check_val("err2_res",  32'(last_res), 32'd0);
        tick();
        check_val("err0_flag", 32'(last_err), 32'd1);
        check_val("err0_res",  32'(last_res), 32'd0);
        check_val("err0_par",  32'(last_par), 32'd0);
        // The pointer is now 2, so requester 2 must win over requester 1.
        set_req(1, 4'd1, 4'd1, 8'h01);
        set_req(2, 4'd1, 4'd1, 8'h01);
        repeat (4) tick();

        // All four held valid from reset: grants 0,1,2,3,0...
        mode = M_KEEP;
        for (int i = 0; i < 4; i++) new_req(i);
        drive();
        async_reset();
        repeat (10) tick();

        // Two accepts in flight, then reset between edges.
        mode = M_DIR;
        clear_all();
        repeat (3) tick();
        set_req(0, 4'd1, 4'd2, 8'h01);
        set_req(1, 4'd3, 4'd4, 8'h04);
        tick();
        tick();
        async_reset();
        set_req(1, 4'd8, 4'd8, 8'h01);
        set_req(3, 4'd9, 4'd9, 8'h01);
        repeat (4) tick();

        // Continuous requests from 1 and 3, with hold raised for 3 cycles.
        mode = M_KEEP;
        clear_all();
        new_req(1);
        new_req(3);
        drive();
        repeat (3) tick();
        bus.hold = 1'b1;
        repeat (3) tick();
        bus.hold = 1'b0;
        repeat (5) tick();

        // Randomized traffic.
        mode = M_RAND;
        repeat (400) tick();

        // Drain.
        mode = M_DIR;
        bus.hold = 1'b0;
        clear_all();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_rr_arbiter
`default_nettype wire
